// File: rtl/block_sum_engine_if.sv
// Memory front-end bundle between the block-sum engine (master) and the
// shared cache front-end (slave). A request is accepted on a cycle where
// mem_valid and mem_ready are both high. mem_wstrb all-ones marks a write and
// zero marks a read. Read data returns later, qualified by mem_rvalid.
interface block_sum_engine_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 256
);
  logic                  mem_valid;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_rvalid;
  logic                  mem_ready;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_rvalid, mem_ready
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_rvalid, mem_ready
  );
endinterface

// File: rtl/block_sum_engine.sv
// Block-sum engine: on start, reads N consecutive words from input_addr, adds
// the LANE_W-bit unsigned lanes of each word and writes one sum per word to
// output_addr+i (sum in lane 0, upper lanes zero), then raises done.
// A job is rejected without memory traffic when N is zero or either address
// range runs past the top of the address space.
// Build option: define SUM_SAT_EN for saturating lane accumulation; a
// saturated word makes error_flag sticky for the job. Without it, sums wrap.
module block_sum_engine #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 256,
  parameter int LANE_W = 32,
  parameter int N_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] input_addr,
  input  logic [ADDR_W-1:0] output_addr,
  input  logic [N_W-1:0]    N,
  output logic              busy,
  output logic              done,
  output logic              error_flag,
  block_sum_engine_if.master mem
);

  localparam int LANES = DATA_W / LANE_W;
  // Range checks need one bit beyond the wider of address and count.
  localparam int CW = ((N_W > ADDR_W) ? N_W : ADDR_W) + 1;
  localparam logic [CW-1:0] ADDR_MAX = CW'({ADDR_W{1'b1}});

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_FIN
  } state_t;

  // Returns {saturated, lane sum}; saturated is only ever set when SUM_SAT_EN is defined.
  function automatic logic [LANE_W:0] lane_sum(input logic [DATA_W-1:0] word);
`ifdef SUM_SAT_EN
    logic [LANE_W+$clog2(LANES):0] acc;
    acc = '0;
    for (int k = 0; k < LANES; k++)
      acc = acc + {{($clog2(LANES)+1){1'b0}}, word[k*LANE_W +: LANE_W]};
    if (acc[LANE_W+$clog2(LANES):LANE_W] != '0)
      return {1'b1, {LANE_W{1'b1}}};
    return {1'b0, acc[LANE_W-1:0]};
`else
    logic [LANE_W-1:0] acc;
    acc = '0;
    for (int k = 0; k < LANES; k++)
      acc = acc + word[k*LANE_W +: LANE_W];
    return {1'b0, acc};
`endif
  endfunction

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  r_mem_valid;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic [DATA_W/8-1:0]   r_mem_wstrb;
  logic [ADDR_W-1:0]     r_in_addr;
  logic [ADDR_W-1:0]     r_out_addr;
  logic [N_W-1:0]        r_n;
  logic [N_W-1:0]        r_idx;
  logic [LANE_W-1:0]     r_sum;

  logic [CW-1:0]         w_in_end;
  logic [CW-1:0]         w_out_end;
  logic                  w_cfg_err;
  logic [LANE_W:0]       w_lane_res;
  logic [N_W-1:0]        w_idx_nxt;

  assign w_in_end   = CW'(r_in_addr)  + CW'(r_n) - CW'(1);
  assign w_out_end  = CW'(r_out_addr) + CW'(r_n) - CW'(1);
  assign w_cfg_err  = (r_n == '0) || (w_in_end > ADDR_MAX) || (w_out_end > ADDR_MAX);
  assign w_lane_res = lane_sum(mem.mem_rdata);
  assign w_idx_nxt  = r_idx + N_W'(1);

  assign busy          = r_busy;
  assign done          = r_done;
  assign error_flag    = r_err;
  assign mem.mem_valid = r_mem_valid;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;
  assign mem.mem_wstrb = r_mem_wstrb;

  // Job sequencer: config latch, range check, one outstanding request at a time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_in_addr   <= '0;
      r_out_addr  <= '0;
      r_n         <= '0;
      r_idx       <= '0;
      r_sum       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_in_addr  <= input_addr;
            r_out_addr <= output_addr;
            r_n        <= N;
            r_idx      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_cfg_err) begin
            r_err   <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_mem_valid <= 1'b1;
            r_mem_addr  <= r_in_addr;
            r_mem_wstrb <= '0;
            r_state     <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          if (mem.mem_ready) begin
            r_mem_valid <= 1'b0;
            r_state     <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (mem.mem_rvalid) begin
            r_sum <= w_lane_res[LANE_W-1:0];
            if (w_lane_res[LANE_W])
              r_err <= 1'b1;
            r_state <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          // First cycle presents the registered sum; ready is ignored until valid is up.
          if (!r_mem_valid) begin
            r_mem_valid <= 1'b1;
            r_mem_addr  <= r_out_addr + r_idx[ADDR_W-1:0];
            r_mem_wdata <= {{(DATA_W-LANE_W){1'b0}}, r_sum};
            r_mem_wstrb <= '1;
          end else if (mem.mem_ready) begin
            r_idx <= w_idx_nxt;
            if (w_idx_nxt == r_n) begin
              r_mem_valid <= 1'b0;
              r_state     <= S_FIN;
            end else begin
              r_mem_valid <= 1'b1;
              r_mem_addr  <= r_in_addr + w_idx_nxt[ADDR_W-1:0];
              r_mem_wstrb <= '0;
              r_state     <= S_RD_REQ;
            end
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_sum_engine.sv
// Bench for block_sum_engine: a memory responder with programmable ready and
// read-data delays, and a scoreboard of expected write-backs built from a lane
// model when each job is launched.
module tb_block_sum_engine;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 256;
  localparam int LANE_W = 32;
  localparam int N_W    = 32;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] input_addr;
  logic [ADDR_W-1:0] output_addr;
  logic [N_W-1:0]    N;
  logic              busy;
  logic              done;
  logic              error_flag;

  block_sum_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif();

  block_sum_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANE_W(LANE_W), .N_W(N_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .input_addr(input_addr), .output_addr(output_addr), .N(N),
    .busy(busy), .done(done), .error_flag(error_flag),
    .mem(mif)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LANE_W-1:0] data;
  } wr_t;

  int n_vec = 0;
  int n_bad = 0;
  logic [DATA_W-1:0] mem_arr [logic [ADDR_W-1:0]];
  wr_t exp_q[$];

  int  ready_wait  = 0;
  int  rv_delay    = 1;
  bit  stray_ready = 0;
  int  n_acc       = 0;
  int  n_valid_cyc = 0;

  bit                 req_seen;
  bit                 acc_armed;
  int                 wait_cnt;
  int                 rv_cnt;
  logic [ADDR_W-1:0]  cap_addr;
  logic [DATA_W-1:0]  cap_wdata;
  logic [DATA_W/8-1:0] cap_wstrb;
  logic [DATA_W-1:0]  rd_word;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit lane total, then wrap or saturate to 32 bits.
  function automatic logic [LANE_W:0] model_sum(input logic [DATA_W-1:0] w);
    logic [63:0] t;
    t = 64'd0;
    for (int k = 0; k < DATA_W / LANE_W; k++) t = t + 64'(w[k*LANE_W +: LANE_W]);
`ifdef SUM_SAT_EN
    if (t > 64'hFFFF_FFFF) return {1'b1, 32'hFFFF_FFFF};
`endif
    return {1'b0, t[31:0]};
  endfunction

  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return '0;
  endfunction

  // Memory responder: acts at negedges, accepts when ready was driven against a valid request.
  initial begin
    mif.mem_ready  = 1'b0;
    mif.mem_rvalid = 1'b0;
    mif.mem_rdata  = '0;
    req_seen = 0; acc_armed = 0; wait_cnt = 0; rv_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mif.mem_ready = 1'b0; mif.mem_rvalid = 1'b0;
        req_seen = 0; acc_armed = 0; wait_cnt = 0; rv_cnt = 0;
      end else begin
        if (acc_armed) begin
          n_acc++;
          if (cap_wstrb == '0) begin
            rd_word = mem_rd(cap_addr);
            rv_cnt  = rv_delay;
          end else begin
            check_eq("wr_strb", cap_wstrb, {32{1'b1}});
            mem_arr[cap_addr] = cap_wdata;
            check_eq("wr_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              wr_t e;
              e = exp_q.pop_front();
              check_eq("wr_addr", cap_addr, e.addr);
              check_eq("wr_data", cap_wdata, {224'd0, e.data});
            end
          end
          req_seen = 0; acc_armed = 0;
        end
        mif.mem_rvalid = 1'b0;
        if (rv_cnt > 0) begin
          rv_cnt--;
          if (rv_cnt == 0) begin
            mif.mem_rvalid = 1'b1;
            mif.mem_rdata  = rd_word;
          end
        end
        if (mif.mem_valid) begin
          n_valid_cyc++;
          if (!req_seen) begin
            req_seen  = 1; wait_cnt = 0;
            cap_addr  = mif.mem_addr;
            cap_wdata = mif.mem_wdata;
            cap_wstrb = mif.mem_wstrb;
          end else begin
            check_eq("hold_addr", mif.mem_addr, cap_addr);
            check_eq("hold_wdata", mif.mem_wdata, cap_wdata);
            check_eq("hold_wstrb", mif.mem_wstrb, cap_wstrb);
          end
          if (wait_cnt >= ready_wait) begin
            mif.mem_ready = 1'b1; acc_armed = 1;
          end else begin
            mif.mem_ready = 1'b0; wait_cnt++;
          end
        end else begin
          mif.mem_ready = stray_ready;
          acc_armed = 0;
        end
      end
    end
  end

  // Launch one job at a negedge and check its completion; exp_lat < 0 skips the latency check.
  task automatic run_job(input logic [ADDR_W-1:0] in_a, input logic [ADDR_W-1:0] out_a,
                         input logic [N_W-1:0] n, input int rw, input int rvd,
                         input bit stray, input bit poke, input int exp_lat);
    logic [LANE_W:0] r;
    bit cfg_err, exp_err;
    int cyc;
    logic [63:0] in_end, out_end;
    in_end  = 64'(in_a)  + 64'(n) - 64'd1;
    out_end = 64'(out_a) + 64'(n) - 64'd1;
    cfg_err = (n == 0) || (in_end > 64'h7FFFF) || (out_end > 64'h7FFFF);
    exp_err = cfg_err;
    if (!cfg_err) begin
      for (int i = 0; i < int'(n); i++) begin
        r = model_sum(mem_rd(ADDR_W'(in_a + i)));
        exp_q.push_back(wr_t'{addr: ADDR_W'(out_a + i), data: r[LANE_W-1:0]});
        if (r[LANE_W]) exp_err = 1;
      end
    end
    ready_wait = rw; rv_delay = rvd; stray_ready = stray;
    n_acc = 0; n_valid_cyc = 0;
    input_addr = in_a; output_addr = out_a; N = n; start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check_eq("busy_on_start", busy, 1);
        check_eq("done_cleared", done, 0);
        check_eq("err_cleared", error_flag, 0);
      end
      start = poke && (cyc == 3);
      if (poke && cyc == 3) begin
        input_addr = 19'h5555; N = 32'd7;
      end
    end while (!done && cyc < 400);
    check_eq("job_done", done, 1);
    if (exp_lat >= 0) check_eq("done_latency", cyc - 1, exp_lat);
    check_eq("busy_end", busy, 0);
    check_eq("error_flag", error_flag, exp_err);
    check_eq("sb_empty", exp_q.size(), 0);
    check_eq("accepts", n_acc, cfg_err ? 0 : 2 * int'(n));
    if (cfg_err) check_eq("no_traffic", n_valid_cyc, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    check_eq("done_held", done, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [DATA_W-1:0] w;
    reset_n = 1'b0; start = 1'b0; input_addr = '0; output_addr = '0; N = '0;
    for (int k = 0; k < 8; k++) begin
      w[k*32 +: 32] = 32'(k);
    end
    mem_arr[19'h0] = w;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = 32'(k + 8);
    mem_arr[19'h1] = w;
    mem_arr[19'h20] = {256{1'b1}};
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = 32'(k) * 32'h0101_0101;
    mem_arr[19'h7FFFF] = w;
    for (int a = 0; a < 4; a++) begin
      for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom;
      mem_arr[19'(32'h100 + a)] = w;
    end
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom_range(0, 32'h0FFF_FFFF);
    mem_arr[19'h40] = w;

    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", error_flag, 0);
    check_eq("rst_valid", mif.mem_valid, 0);
    check_eq("rst_addr", mif.mem_addr, 0);
    check_eq("rst_wstrb", mif.mem_wstrb, 0);
    check_eq("rst_wdata", mif.mem_wdata, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Two-word job, zero-wait memory, stray ready while idle.
    run_job(19'h0, 19'h10, 32'd2, 0, 1, 1'b1, 1'b0, -1);
    check_eq("t1_mem10", mem_rd(19'h10), 256'd28);
    check_eq("t1_mem11", mem_rd(19'h11), 256'd92);

    // Empty job and out-of-range jobs.
    run_job(19'h0, 19'h10, 32'd0, 0, 1, 1'b1, 1'b0, 2);
    run_job(19'h7FFFF, 19'h10, 32'd2, 0, 1, 1'b0, 1'b0, -1);
    run_job(19'h0, 19'h7FFFF, 32'd2, 0, 1, 1'b0, 1'b0, -1);
    run_job(19'h7FFFF, 19'h7FFFF, 32'd1, 0, 1, 1'b0, 1'b0, -1);
    check_eq("top_word", mem_rd(19'h7FFFF), 256'h1C1C1C1C);

    // Slow memory, plus a start pulse mid-job that must be ignored.
    run_job(19'h0, 19'h18, 32'd2, 5, 3, 1'b0, 1'b1, -1);
    check_eq("t4_mem18", mem_rd(19'h18), 256'd28);
    check_eq("t4_mem19", mem_rd(19'h19), 256'd92);

    // All-ones lanes.
    run_job(19'h20, 19'h30, 32'd1, 0, 1, 1'b0, 1'b0, -1);
`ifdef SUM_SAT_EN
    check_eq("t5_sum", mem_rd(19'h30), 256'hFFFF_FFFF);
`else
    check_eq("t5_sum", mem_rd(19'h30), 256'hFFFF_FFF8);
`endif

    // Random words with mixed delays.
    run_job(19'h100, 19'h200, 32'd4, 2, 2, 1'b1, 1'b0, -1);

    // Abort in RD_WAIT by reset, then rerun.
    ready_wait = 0; rv_delay = 50; stray_ready = 0; n_acc = 0;
    input_addr = 19'h40; output_addr = 19'h50; N = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (n_acc < 1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t6_rd_accept", n_acc, 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6_busy", busy, 0);
    check_eq("t6_done", done, 0);
    check_eq("t6_err", error_flag, 0);
    check_eq("t6_valid", mif.mem_valid, 0);
    check_eq("t6_addr", mif.mem_addr, 0);
    check_eq("t6_wstrb", mif.mem_wstrb, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    run_job(19'h40, 19'h50, 32'd1, 0, 1, 1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
